// File: rtl/debounce_multi.sv
// ----------------------------------------------------------------------------
// debounce_multi
//   N-channel push-button conditioner. Every channel owns a synchroniser chain
//   and a stability counter; it produces a clean debounced level plus
//   registered one-cycle press and release strobes, all in the clk domain.
//
//   Optional feature macro: HOLD_REPEAT_EN
//     Defined   -> while a button stays held, press_pulse re-fires HOLD_CYCLES
//                  cycles after the initial press, then every REPEAT_CYCLES.
//     Undefined -> press_pulse fires exactly once per debounced press; no
//                  hold counters exist.
//
// Ports
//   clk            in   1     system clock
//   rst            in   1     synchronous, active-high reset
//   btn_in         in   N_CH  raw asynchronous button levels, bit i = channel i
//   btn_out        out  N_CH  debounced level
//   press_pulse    out  N_CH  one-cycle strobe on debounced 0->1 (and repeats)
//   release_pulse  out  N_CH  one-cycle strobe on debounced 1->0
// ----------------------------------------------------------------------------
module debounce_multi #(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_MAX       = 1_000_000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    // Stability counter only ever holds 0 .. CNT_MAX-1.
    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be >= 2");
    end
    if (CNT_MAX < 2) begin : g_bad_cnt
        $error("debounce_multi: CNT_MAX must be >= 2");
    end
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_hold
        $error("debounce_multi: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    // ------------------------------------------------------------------
    // Synchroniser chains, all channels in parallel.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= btn_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int unsigned HOLD_MAX =
        (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // Per-channel debounce (and optional auto-repeat).
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;
        logic             r_prs;
        logic             r_rel;
        logic             w_s;
        logic             w_diff;
        logic             w_done;

        assign w_s    = r_sync[SYNC_STAGES-1][i];
        assign w_diff = w_s ^ r_lvl;
        // Level flips on this edge.
        assign w_done = w_diff && (r_cnt == CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
                r_prs <= 1'b0;
                r_rel <= 1'b0;
            end else begin
                r_prs <= 1'b0;
                r_rel <= 1'b0;
                if (!w_diff) begin
                    // Any agreeing sample restarts the stability window.
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_lvl <= w_s;
                    r_cnt <= '0;
                    r_prs <= w_s;
                    r_rel <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

`ifdef HOLD_REPEAT_EN
        logic [HOLD_W-1:0] r_hcnt;
        logic              r_rep_phase;
        logic              r_rpt;

        // r_rep_phase selects the first (long) delay or the repeat period.
        // A repeat falling due on the releasing edge is dropped.
        always_ff @(posedge clk) begin
            if (rst || !r_lvl) begin
                r_hcnt      <= '0;
                r_rep_phase <= 1'b0;
                r_rpt       <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (r_hcnt == (r_rep_phase ? REP_LAST : HOLD_LAST)) begin
                    r_hcnt      <= '0;
                    r_rep_phase <= 1'b1;
                    r_rpt       <= ~w_done;
                end else begin
                    r_hcnt <= r_hcnt + HOLD_W'(1);
                end
            end
        end

        assign press_pulse[i] = r_prs | r_rpt;
`else
        assign press_pulse[i] = r_prs;
`endif

        assign btn_out[i]       = r_lvl;
        assign release_pulse[i] = r_rel;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// ----------------------------------------------------------------------------
// tb_debounce_multi
//   Directed bench for debounce_multi with N_CH=3, SYNC_STAGES=2, CNT_MAX=8,
//   HOLD_CYCLES=20, REPEAT_CYCLES=6. A level change driven just after edge k
//   is first sampled at edge k+1 and appears on btn_out at edge k+10.
//   Observed value per cycle is {btn_out, press_pulse, release_pulse}.
// ----------------------------------------------------------------------------
module tb_debounce_multi;

    logic       clk;
    logic       rst;
    logic [2:0] btn_in;
    logic [2:0] btn_out;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;

    int n_total;
    int n_pass;

    debounce_multi #(
        .N_CH          (3),
        .SYNC_STAGES   (2),
        .CNT_MAX       (8),
        .HOLD_CYCLES   (20),
        .REPEAT_CYCLES (6)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_out       (btn_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out/prs/rel=%b/%b/%b expected %b/%b/%b",
                     tag, got[8:6], got[5:3], got[2:0], exp[8:6], exp[5:3], exp[2:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle, compare against an explicit level/press/release triple.
    task automatic ev(input logic [2:0] lvl, input logic [2:0] prs,
                      input logic [2:0] rel, input string tag);
        tick();
        check(tag, {btn_out, press_pulse, release_pulse}, {lvl, prs, rel});
    endtask

    // n cycles with a steady level and no strobes.
    task automatic quiet(input int n, input logic [2:0] lvl, input string tag);
        for (int c = 0; c < n; c++) begin
            ev(lvl, 3'b000, 3'b000, tag);
        end
    endtask

    initial begin
        logic exp_prs;
        n_total = 0;
        n_pass  = 0;

        // 1: reset with all buttons held, then press appears 10 edges later.
        rst    = 1'b1;
        btn_in = 3'b111;
        quiet(3, 3'b000, "rst_hold");
        rst = 1'b0;
        quiet(9, 3'b000, "t1_wait");
        ev(3'b111, 3'b111, 3'b000, "t1_press");
        btn_in = 3'b000;
        quiet(9, 3'b111, "t1_held");
        ev(3'b000, 3'b000, 3'b111, "t1_release");

        // 2: clean press and release on ch0.
        btn_in = 3'b001;
        quiet(9, 3'b000, "t2_wait");
        ev(3'b001, 3'b001, 3'b000, "t2_press");
        btn_in = 3'b000;
        quiet(9, 3'b001, "t2_held");
        ev(3'b000, 3'b000, 3'b001, "t2_release");
        quiet(3, 3'b000, "t2_idle");

        // 3: ch1 bounces every 3 cycles, then settles high.
        btn_in = 3'b010; quiet(3, 3'b000, "t3_bounce");
        btn_in = 3'b000; quiet(3, 3'b000, "t3_bounce");
        btn_in = 3'b010; quiet(3, 3'b000, "t3_bounce");
        btn_in = 3'b000; quiet(3, 3'b000, "t3_bounce");
        btn_in = 3'b010;
        quiet(9, 3'b000, "t3_wait");
        ev(3'b010, 3'b010, 3'b000, "t3_press");

        // ch1 release and ch2 press together.
        btn_in = 3'b100;
        quiet(9, 3'b010, "t3b_wait");
        ev(3'b100, 3'b100, 3'b010, "t3b_swap");

        // 4: ch0 press and ch2 release on the same edge; ch1 silent.
        btn_in = 3'b001;
        quiet(9, 3'b100, "t4_wait");
        ev(3'b001, 3'b001, 3'b100, "t4_swap");
        btn_in = 3'b000;
        quiet(9, 3'b001, "t4_held");
        ev(3'b000, 3'b000, 3'b001, "t4_release");

        // 5: reset while ch0's count is at 5; progress discarded.
        btn_in = 3'b001;
        quiet(7, 3'b000, "t5_count");
        rst = 1'b1;
        quiet(2, 3'b000, "t5_rst");
        rst = 1'b0;
        quiet(9, 3'b000, "t5_wait");
        ev(3'b001, 3'b001, 3'b000, "t5_press");
        btn_in = 3'b000;
        quiet(9, 3'b001, "t5_held");
        ev(3'b000, 3'b000, 3'b001, "t5_release");
        quiet(2, 3'b000, "t5_idle");

        // 6: ch0 held 40 cycles after its press strobe (t0), then released.
        //    Repeats (if enabled) at t0+20,26,32,38,44; the one due at t0+50
        //    coincides with the release and must be dropped.
        btn_in = 3'b001;
        quiet(9, 3'b000, "t6_wait");
        ev(3'b001, 3'b001, 3'b000, "t6_press");
        for (int o = 1; o <= 50; o++) begin
`ifdef HOLD_REPEAT_EN
            exp_prs = (o == 20) || (o == 26) || (o == 32) || (o == 38) || (o == 44);
`else
            exp_prs = 1'b0;
`endif
            ev((o < 50) ? 3'b001 : 3'b000, {2'b00, exp_prs},
               (o == 50) ? 3'b001 : 3'b000, "t6_hold");
            if (o == 40) btn_in = 3'b000;
        end
        quiet(3, 3'b000, "t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
